// File: rtl/ysyx_24090012_idu_pkg.sv
// ysyx_24090012 decode stage: shared opcodes, enums and the decoded bundle.
package ysyx_24090012_idu_pkg;

   localparam int DEC_IMM_W = 32;
   localparam int DEC_IDX_W = 4;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_FENCE_I = 32'h0000100F;
   localparam logic [31:0] INST_EBREAK  = 32'h00100073;
   localparam logic [31:0] INST_ECALL   = 32'h00000073;
   localparam logic [31:0] INST_MRET    = 32'h30200073;

   localparam logic [6:0] F7_ALT = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_PASS = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      FU_ALU = 3'd0,
      FU_BRU = 3'd1,
      FU_LSU = 3'd2,
      FU_CSR = 3'd3,
      FU_SYS = 3'd4
   } fu_sel_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   typedef struct packed {
      logic [DEC_IDX_W-1:0] rs1;
      logic [DEC_IDX_W-1:0] rs2;
      logic [DEC_IDX_W-1:0] rd;
      logic [DEC_IMM_W-1:0] imm;
      alu_op_e              alu_op;
      fu_sel_e              fu_sel;
      logic                 rf_wen;
      logic                 mem_ren;
      logic                 mem_wen;
      logic [2:0]           mem_size;
      logic                 is_branch;
      logic                 is_jal;
      logic                 is_jalr;
      logic                 fence_i;
      logic                 ebreak;
      logic                 illegal;
   } dec_t;

   // alt selects SUB/SRA where funct7[5] distinguishes them
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                           input logic       alt);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ysyx_24090012_imm_gen.sv
// ysyx_24090012 immediate generator: sign-extended immediate per format.
module ysyx_24090012_imm_gen
   import ysyx_24090012_idu_pkg::*;
(
   input  logic [31:0]          inst,
   input  imm_fmt_e             fmt,
   output logic [DEC_IMM_W-1:0] imm
);

   always_comb begin
      imm = '0;
      unique case (fmt)
         IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                       inst[30:25], inst[11:8], 1'b0};
         IMM_U: imm = {inst[31:12], 12'b0};
         IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12],
                       inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_24090012_idu.sv
// ysyx_24090012 decode stage: RV32E decode into a one-entry register
// toward the EXU, with valid/ready backpressure and flush.
module ysyx_24090012_idu
   import ysyx_24090012_idu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_W    = 64,
   parameter int RF_IDX_W = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     in_pc,
   input  logic [31:0]         in_inst,
   input  logic [NUM_W-1:0]    in_num,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [NUM_W-1:0]    out_num,
   output logic [RF_IDX_W-1:0] out_rs1,
   output logic [RF_IDX_W-1:0] out_rs2,
   output logic [RF_IDX_W-1:0] out_rd,
   output logic [XLEN-1:0]     out_imm,
   output logic [3:0]          out_alu_op,
   output logic [2:0]          out_fu_sel,
   output logic                out_rf_wen,
   output logic                out_mem_ren,
   output logic                out_mem_wen,
   output logic [2:0]          out_mem_size,
   output logic                out_is_branch,
   output logic                out_is_jal,
   output logic                out_is_jalr,
   output logic                out_fence_i,
   output logic                out_ebreak,
   output logic                out_illegal
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = in_inst[6:0];
   assign f3  = in_inst[14:12];
   assign f7  = in_inst[31:25];

   imm_fmt_e             fmt;
   alu_op_e              alu;
   fu_sel_e              fu;
   logic                 wen, ren, men;
   logic [2:0]           msize;
   logic                 br, jal, jalr;
   logic                 use_rs1, use_rs2, use_rd;
   logic                 bad, reg_bad, illegal;
   logic [DEC_IMM_W-1:0] imm;
   dec_t                 dec;
   dec_t                 q;
   logic [XLEN-1:0]      pc_q;
   logic [NUM_W-1:0]     num_q;
   logic                 fire_in, fire_out;

   always_comb begin
      fmt     = IMM_NONE;
      alu     = ALU_ADD;
      fu      = FU_ALU;
      wen     = 1'b0;
      ren     = 1'b0;
      men     = 1'b0;
      msize   = 3'b000;
      br      = 1'b0;
      jal     = 1'b0;
      jalr    = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      bad     = 1'b0;
      unique case (1'b1)
         opc == OPC_LUI: begin
            fmt    = IMM_U;
            alu    = ALU_PASS;
            wen    = 1'b1;
            use_rd = 1'b1;
         end
         opc == OPC_AUIPC: begin
            fmt    = IMM_U;
            wen    = 1'b1;
            use_rd = 1'b1;
         end
         opc == OPC_JAL: begin
            fmt    = IMM_J;
            fu     = FU_BRU;
            jal    = 1'b1;
            wen    = 1'b1;
            use_rd = 1'b1;
         end
         opc == OPC_JALR: begin
            fmt     = IMM_I;
            fu      = FU_BRU;
            jalr    = 1'b1;
            wen     = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            bad     = f3 != 3'b000;
         end
         opc == OPC_BRANCH: begin
            fmt     = IMM_B;
            fu      = FU_BRU;
            br      = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            alu     = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
            bad     = f3[2:1] == 2'b01;
         end
         opc == OPC_LOAD: begin
            fmt     = IMM_I;
            fu      = FU_LSU;
            ren     = 1'b1;
            wen     = 1'b1;
            msize   = f3;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            bad     = f3 == 3'b011 || f3[2:1] == 2'b11;
         end
         opc == OPC_STORE: begin
            fmt     = IMM_S;
            fu      = FU_LSU;
            men     = 1'b1;
            msize   = f3;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            bad     = f3[2] || f3 == 3'b011;
         end
         opc == OPC_OP_IMM: begin
            fmt     = IMM_I;
            wen     = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            alu     = alu_from_f3(f3, f3 == 3'b101 && f7[5]);
            if (f3 == 3'b001)
               bad = f7 != 7'b0;
            else if (f3 == 3'b101)
               bad = f7 != 7'b0 && f7 != F7_ALT;
         end
         opc == OPC_OP: begin
            wen     = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            alu     = alu_from_f3(f3, f7[5]);
            bad     = !(f7 == 7'b0 ||
                        (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
         end
         opc == OPC_MISC: begin
            fmt = IMM_I;
            fu  = FU_SYS;
            bad = !(f3 == 3'b000 || in_inst == INST_FENCE_I);
         end
         opc == OPC_SYSTEM: begin
            fmt = IMM_I;
            if (f3 == 3'b000) begin
               fu  = FU_SYS;
               bad = !(in_inst == INST_ECALL || in_inst == INST_EBREAK ||
                       in_inst == INST_MRET);
            end else begin
               // csrr*i carries a 5-bit uimm in the rs1 slot
               fu      = FU_CSR;
               wen     = 1'b1;
               use_rd  = 1'b1;
               use_rs1 = !f3[2];
               bad     = f3 == 3'b100;
            end
         end
         default: bad = 1'b1;
      endcase
   end

   ysyx_24090012_imm_gen u_imm_gen (
      .inst (in_inst),
      .fmt  (fmt),
      .imm  (imm)
   );

   assign reg_bad = (use_rs1 && in_inst[19]) ||
                    (use_rs2 && in_inst[24]) ||
                    (use_rd  && in_inst[11]);
   assign illegal = bad || reg_bad;

   always_comb begin
      dec           = '0;
      dec.rs1       = in_inst[18:15];
      dec.rs2       = in_inst[23:20];
      dec.rd        = in_inst[10:7];
      dec.imm       = imm;
      dec.alu_op    = alu;
      dec.fu_sel    = fu;
      dec.rf_wen    = wen && !illegal && in_inst[11:7] != 5'd0;
      dec.mem_ren   = ren && !illegal;
      dec.mem_wen   = men && !illegal;
      dec.mem_size  = msize;
      dec.is_branch = br;
      dec.is_jal    = jal;
      dec.is_jalr   = jalr;
      dec.fence_i   = in_inst == INST_FENCE_I;
      dec.ebreak    = in_inst == INST_EBREAK;
      dec.illegal   = illegal;
   end

   assign in_ready = !out_valid || out_ready;
   assign fire_in  = in_valid && in_ready && !flush;
   assign fire_out = out_valid && out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         q         <= '0;
         pc_q      <= '0;
         num_q     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (fire_in) begin
         out_valid <= 1'b1;
         q         <= dec;
         pc_q      <= in_pc;
         num_q     <= in_num;
      end else if (fire_out) begin
         out_valid <= 1'b0;
      end
   end

   assign out_pc        = pc_q;
   assign out_num       = num_q;
   assign out_rs1       = q.rs1;
   assign out_rs2       = q.rs2;
   assign out_rd        = q.rd;
   assign out_imm       = q.imm;
   assign out_alu_op    = q.alu_op;
   assign out_fu_sel    = q.fu_sel;
   assign out_rf_wen    = q.rf_wen;
   assign out_mem_ren   = q.mem_ren;
   assign out_mem_wen   = q.mem_wen;
   assign out_mem_size  = q.mem_size;
   assign out_is_branch = q.is_branch;
   assign out_is_jal    = q.is_jal;
   assign out_is_jalr   = q.is_jalr;
   assign out_fence_i   = q.fence_i;
   assign out_ebreak    = q.ebreak;
   assign out_illegal   = q.illegal;

endmodule

// File: tb/tb_ysyx_24090012_idu.sv
// ysyx_24090012 decode stage bench: directed vectors,
// hand-computed expectations.
module tb_ysyx_24090012_idu;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_inst;
   logic [63:0] in_num;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_pc;
   logic [63:0] out_num;
   logic [3:0]  out_rs1, out_rs2, out_rd;
   logic [31:0] out_imm;
   logic [3:0]  out_alu_op;
   logic [2:0]  out_fu_sel;
   logic        out_rf_wen, out_mem_ren, out_mem_wen;
   logic [2:0]  out_mem_size;
   logic        out_is_branch, out_is_jal, out_is_jalr;
   logic        out_fence_i, out_ebreak, out_illegal;

   int errs   = 0;
   int checks = 0;

   always #5 clock = ~clock;

   ysyx_24090012_idu dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pc         (in_pc),
      .in_inst       (in_inst),
      .in_num        (in_num),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_num       (out_num),
      .out_rs1       (out_rs1),
      .out_rs2       (out_rs2),
      .out_rd        (out_rd),
      .out_imm       (out_imm),
      .out_alu_op    (out_alu_op),
      .out_fu_sel    (out_fu_sel),
      .out_rf_wen    (out_rf_wen),
      .out_mem_ren   (out_mem_ren),
      .out_mem_wen   (out_mem_wen),
      .out_mem_size  (out_mem_size),
      .out_is_branch (out_is_branch),
      .out_is_jal    (out_is_jal),
      .out_is_jalr   (out_is_jalr),
      .out_fence_i   (out_fence_i),
      .out_ebreak    (out_ebreak),
      .out_illegal   (out_illegal)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [31:0] inst, input logic [63:0] num);
      in_valid = 1'b1;
      in_inst  = inst;
      in_num   = num;
      in_pc    = 32'h8000_0000 + 32'(num) * 4;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_inst   = '0;
      in_num    = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_imm", out_imm, 0);
      check("rst_num", out_num, 0);
      tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_valid2", out_valid, 0);

      // addi x1,x0,5
      issue(32'h00500093, 1);
      check("addi_valid", out_valid, 1);
      check("addi_rd", out_rd, 1);
      check("addi_rs1", out_rs1, 0);
      check("addi_imm", out_imm, 5);
      check("addi_wen", out_rf_wen, 1);
      check("addi_alu", out_alu_op, 0);
      check("addi_pc", out_pc, 32'h8000_0004);
      check("addi_num", out_num, 1);

      // beq x1,x2,-4
      issue(32'hFE208EE3, 2);
      check("beq_br", out_is_branch, 1);
      check("beq_rs1", out_rs1, 1);
      check("beq_rs2", out_rs2, 2);
      check("beq_imm", out_imm, 32'hFFFF_FFFC);
      check("beq_wen", out_rf_wen, 0);
      check("beq_ill", out_illegal, 0);
      check("beq_fu", out_fu_sel, 1);

      // lui x1,0x12345
      issue(32'h123450B7, 3);
      check("lui_imm", out_imm, 32'h1234_5000);
      check("lui_rd", out_rd, 1);
      check("lui_alu", out_alu_op, 10);

      // addi x16,x0,0 uses a register outside RV32E
      issue(32'h00000813, 4);
      check("x16_ill", out_illegal, 1);
      check("x16_wen", out_rf_wen, 0);

      // sw x2,8(x1)
      issue(32'h0020A423, 5);
      check("sw_wen_mem", out_mem_wen, 1);
      check("sw_ren", out_mem_ren, 0);
      check("sw_size", out_mem_size, 2);
      check("sw_imm", out_imm, 8);
      check("sw_rfwen", out_rf_wen, 0);

      // jal x1,+2048
      issue(32'h001000EF, 6);
      check("jal_flag", out_is_jal, 1);
      check("jal_imm", out_imm, 32'h800);
      check("jal_wen", out_rf_wen, 1);

      // addi x0,x0,1
      issue(32'h00100013, 7);
      check("x0_wen", out_rf_wen, 0);
      check("x0_ill", out_illegal, 0);

      issue(32'hFFFF_FFFF, 8);
      check("bad_ill", out_illegal, 1);
      check("bad_imm", out_imm, 0);

      issue(32'h0000100F, 9);
      check("fencei", out_fence_i, 1);
      check("fencei_ill", out_illegal, 0);

      issue(32'h00100073, 10);
      check("ebreak", out_ebreak, 1);
      check("ebreak_fu", out_fu_sel, 4);
      check("ebreak_fencei", out_fence_i, 0);

      // backpressure: addi held while lui waits
      issue(32'h00500093, 11);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h123450B7;
      in_num    = 12;
      #1;
      check("bp_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_valid", out_valid, 1);
         check("bp_num", out_num, 11);
         check("bp_imm", out_imm, 5);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release", in_ready, 1);
      tick();
      check("b2b_num1", out_num, 12);
      check("b2b_imm1", out_imm, 32'h1234_5000);
      in_inst = 32'hFE208EE3;
      in_num  = 13;
      tick();
      check("b2b_num2", out_num, 13);
      check("b2b_valid2", out_valid, 1);
      in_valid = 1'b0;
      tick();
      check("drain_valid", out_valid, 0);

      // flush while stalled
      issue(32'h00500093, 20);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h001000EF;
      in_num    = 21;
      tick();
      check("fl_stall_num", out_num, 20);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_valid", out_valid, 0);
      out_ready = 1'b1;
      tick();
      check("fl_gone1", out_valid, 0);
      tick();
      check("fl_gone2", out_valid, 0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_inst  = 32'h00500093;
      in_num   = 22;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_empty", out_valid, 0);

      // reset during a stall
      issue(32'h123450B7, 30);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00500093;
      in_num    = 31;
      tick();
      check("rs_stall", out_valid, 1);
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      check("rs_valid", out_valid, 0);
      check("rs_imm", out_imm, 0);
      check("rs_num", out_num, 0);
      check("rs_ready", in_ready, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
